sram_frame_writer: RTL and testbench



---
 rtl/sram_frame_writer_pkg.sv | 25 ++
 rtl/sram_frame_writer_if.sv | 32 +++
 rtl/byte_lane_packer.sv | 51 +++++
 rtl/sram_frame_writer.sv | 128 ++++++++++++
 tb/tb_sram_frame_writer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_frame_writer_pkg.sv
// Shared types and helpers for the SRAM frame writer: FSM states, lane count
// and the byte-count to byteenable mapping.
package sram_frame_writer_pkg;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DRAIN   = 2'd3
   } state_e;

   // Number of filled lanes -> contiguous low-lane enable mask.
   function automatic logic [LANES-1:0] lane_mask(input logic [2:0] count);
      case (count)
         3'd0:    lane_mask = 4'b0000;
         3'd1:    lane_mask = 4'b0001;
         3'd2:    lane_mask = 4'b0011;
         3'd3:    lane_mask = 4'b0111;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/sram_frame_writer_if.sv
// Byte-stream input, memory write port and status bundle of the frame writer.
// The slave modport is the writer itself; master is whoever drives the stream.
interface sram_frame_writer_if #(
   parameter int ADDR_W = 13
);
   logic              start;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              mem_clken;
   logic [15:0]       byte_count;
   logic              done;
   logic              overflow;

   modport slave (
      input  start, in_data, in_valid, in_last,
      output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken, byte_count, done, overflow
   );

   modport master (
      output start, in_data, in_valid, in_last,
      input  in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken, byte_count, done, overflow
   );
endinterface

// File: rtl/byte_lane_packer.sv
// Little-endian byte packer: each load drops a byte into the next free lane of
// a 32-bit word and extends the lane mask; clear empties word, count and mask.
module byte_lane_packer
   import sram_frame_writer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  logic [7:0]           data_i,
   output logic [8*LANES-1:0]   word_o,
   output logic [LANES-1:0]     mask_o,
   output logic [2:0]           lane_cnt_o
);

   logic [8*LANES-1:0] word_q, word_d;
   logic [LANES-1:0]   mask_q, mask_d;
   logic [2:0]         lane_q, lane_d;

   always_comb begin
      word_d = word_q;
      mask_d = mask_q;
      lane_d = lane_q;
      if (clear_i) begin
         word_d = '0;
         mask_d = '0;
         lane_d = '0;
      end else if (load_i && (lane_q < 3'(LANES))) begin
         word_d[{lane_q[1:0], 3'b000} +: 8] = data_i;
         lane_d = lane_q + 3'd1;
         mask_d = lane_mask(lane_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         mask_q <= '0;
         lane_q <= '0;
      end else begin
         word_q <= word_d;
         mask_q <= mask_d;
         lane_q <= lane_d;
      end
   end

   assign word_o     = word_q;
   assign mask_o     = mask_q;
   assign lane_cnt_o = lane_q;

endmodule

// File: rtl/sram_frame_writer.sv
// Frame writer top: collects stream bytes into words, writes them to
// consecutive memory words from BASE_ADDR and reports count/done/overflow.
module sram_frame_writer
   import sram_frame_writer_pkg::*;
#(
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 5120,
   parameter int ADDR_W    = 13
) (
   input  logic               clk,
   input  logic               reset_n,
   sram_frame_writer_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH + 1);

   state_e            state_q;
   logic [IDX_W-1:0]  word_idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       byte_cnt_q, byte_cnt_d;
   logic              overflow_q;
   logic              write_q;
   logic              done_q;
   logic              last_q;
   logic              clken_q;

   logic [8*LANES-1:0] pk_word;
   logic [LANES-1:0]   pk_mask;
   logic [2:0]         pk_lane;

   logic accept;
   logic full;
   logic word_end;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign accept     = bus.in_valid && (state_q == COLLECT);
   // Once every word slot is used, further bytes are swallowed rather than stored.
   assign full       = (word_idx_q == IDX_W'(DEPTH));
   assign word_end   = (pk_lane == 3'(LANES - 1)) || bus.in_last;
   assign byte_cnt_d = sat_inc16(byte_cnt_q);

   byte_lane_packer u_packer (
      .clk        (clk),
      .rst_n      (reset_n),
      .clear_i    (bus.start || (state_q == WRITE)),
      .load_i     (accept && !bus.start && !full),
      .data_i     (bus.in_data),
      .word_o     (pk_word),
      .mask_o     (pk_mask),
      .lane_cnt_o (pk_lane)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         word_idx_q <= '0;
         addr_q     <= '0;
         byte_cnt_q <= '0;
         overflow_q <= 1'b0;
         write_q    <= 1'b0;
         done_q     <= 1'b0;
         last_q     <= 1'b0;
         clken_q    <= 1'b0;
      end else begin
         clken_q <= 1'b1;
         write_q <= 1'b0;
         done_q  <= 1'b0;
         if (bus.start) begin
            // Arming always wins: any partial word or pending write is dropped.
            state_q    <= COLLECT;
            word_idx_q <= '0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
            last_q     <= 1'b0;
         end else begin
            case (state_q)
               IDLE: state_q <= IDLE;
               COLLECT: begin
                  if (accept) begin
                     if (full) begin
                        overflow_q <= 1'b1;
                        if (bus.in_last) begin
                           state_q <= DRAIN;
                           done_q  <= 1'b1;
                        end
                     end else begin
                        byte_cnt_q <= byte_cnt_d;
                        if (word_end) begin
                           state_q <= WRITE;
                           write_q <= 1'b1;
                           last_q  <= bus.in_last;
                        end
                     end
                  end
               end
               WRITE: begin
                  word_idx_q <= word_idx_q + IDX_W'(1);
                  addr_q     <= addr_q + ADDR_W'(1);
                  if (last_q) begin
                     state_q <= DRAIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= COLLECT;
                  end
               end
               DRAIN:   state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.in_ready       = (state_q == COLLECT);
   assign bus.mem_address    = addr_q;
   assign bus.mem_byteenable = pk_mask;
   assign bus.mem_writedata  = pk_word;
   assign bus.mem_chipselect = write_q;
   assign bus.mem_write      = write_q;
   assign bus.mem_clken      = clken_q;
   assign bus.byte_count     = byte_cnt_q;
   assign bus.done           = done_q;
   assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer: table-driven frames on a full-depth
// instance plus overflow, abort and reset sequences on a DEPTH=2 instance.
module tb_sram_frame_writer;

   typedef struct {
      logic [7:0] first;
      logic [7:0] step;
      int         n;
      int         exp_cnt;
      int         exp_edges;
      int         exp_lows;
   } frame_t;

   typedef struct {
      logic [12:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic s_start = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic s_valid = 1'b0;
   logic s_last = 1'b0;
   logic sel = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int cs_err = 0;
   int doneA = 0;

   wr_t wq1[$];
   wr_t wq2[$];
   frame_t frames[3];
   wr_t exp1[11];
   wr_t exp2[2];

   sram_frame_writer_if #(.ADDR_W(13)) ifA ();
   sram_frame_writer_if #(.ADDR_W(13)) ifB ();

   assign ifA.start    = s_start & ~sel;
   assign ifA.in_valid = s_valid & ~sel;
   assign ifA.in_data  = s_data;
   assign ifA.in_last  = s_last;
   assign ifB.start    = s_start & sel;
   assign ifB.in_valid = s_valid & sel;
   assign ifB.in_data  = s_data;
   assign ifB.in_last  = s_last;

   wire        rdy_w = sel ? ifB.in_ready : ifA.in_ready;
   wire        done_w = sel ? ifB.done : ifA.done;
   wire [15:0] cnt_w = sel ? ifB.byte_count : ifA.byte_count;

   sram_frame_writer #(.BASE_ADDR(100), .DEPTH(5120), .ADDR_W(13)) dut (
      .clk(clk), .reset_n(reset_n), .bus(ifA.slave)
   );

   sram_frame_writer #(.BASE_ADDR(0), .DEPTH(2), .ADDR_W(13)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(ifB.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ifA.mem_write) wq1.push_back('{ifA.mem_address, ifA.mem_byteenable, ifA.mem_writedata});
      if (ifB.mem_write) wq2.push_back('{ifB.mem_address, ifB.mem_byteenable, ifB.mem_writedata});
      if (ifA.mem_write !== ifA.mem_chipselect) cs_err++;
      if (ifB.mem_write !== ifB.mem_chipselect) cs_err++;
      if (ifA.done) doneA++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] first, input logic [7:0] step, input int n,
                       input bit last, output int edges, output int lows);
      logic [7:0] b;
      bit rdy;
      int guard;
      b = first;
      edges = 0;
      lows = 0;
      for (int i = 0; i < n; i++) begin
         s_data  = b;
         s_valid = 1'b1;
         s_last  = last && (i == n - 1);
         guard   = 0;
         do begin
            @(negedge clk);
            rdy = rdy_w;
            if (!rdy) lows++;
            @(posedge clk); #1;
            edges++;
            guard++;
         end while (!rdy && guard < 20);
         if (!rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept timeout: byte %0d not accepted within %0d cycles", i, guard);
         end
         b = b + step;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_off, input logic [15:0] exp_cnt);
      int off;
      bit seen;
      off = 0;
      seen = 0;
      for (int k = 1; k <= 6 && !seen; k++) begin
         @(negedge clk);
         if (done_w) begin
            seen = 1;
            off = k;
         end
      end
      chk({tag, " done offset"}, 32'(off), 32'(exp_off));
      chk({tag, " byte_count"}, {16'h0, cnt_w}, {16'h0, exp_cnt});
      @(negedge clk);
      chk({tag, " done one cycle"}, {31'h0, done_w}, 32'h0);
   endtask

   initial begin
      int edges, lows, nwr, dbefore;

      frames[0] = '{8'h11, 8'h11, 8, 8, 9, 1};
      frames[1] = '{8'hAA, 8'h11, 5, 5, 6, 1};
      frames[2] = '{8'h01, 8'h01, 20, 20, 24, 4};

      exp1[0]  = '{13'd100, 4'b1111, 32'h44332211};
      exp1[1]  = '{13'd101, 4'b1111, 32'h88776655};
      exp1[2]  = '{13'd100, 4'b1111, 32'hDDCCBBAA};
      exp1[3]  = '{13'd101, 4'b0001, 32'h000000EE};
      exp1[4]  = '{13'd100, 4'b1111, 32'h04030201};
      exp1[5]  = '{13'd101, 4'b1111, 32'h08070605};
      exp1[6]  = '{13'd102, 4'b1111, 32'h0C0B0A09};
      exp1[7]  = '{13'd103, 4'b1111, 32'h100F0E0D};
      exp1[8]  = '{13'd104, 4'b1111, 32'h14131211};
      exp1[9]  = '{13'd100, 4'b1111, 32'hA3A2A1A0};
      exp1[10] = '{13'd100, 4'b1111, 32'h04030201};

      exp2[0] = '{13'd0, 4'b1111, 32'h04030201};
      exp2[1] = '{13'd1, 4'b1111, 32'h08070605};

      // Reset state
      #12;
      chk("rst in_ready", {31'h0, ifA.in_ready}, 32'h0);
      chk("rst mem_write", {31'h0, ifA.mem_write}, 32'h0);
      chk("rst mem_chipselect", {31'h0, ifA.mem_chipselect}, 32'h0);
      chk("rst done", {31'h0, ifA.done}, 32'h0);
      chk("rst overflow", {31'h0, ifA.overflow}, 32'h0);
      chk("rst mem_address", {19'h0, ifA.mem_address}, 32'h0);
      chk("rst mem_byteenable", {28'h0, ifA.mem_byteenable}, 32'h0);
      chk("rst mem_writedata", ifA.mem_writedata, 32'h0);
      chk("rst byte_count", {16'h0, ifA.byte_count}, 32'h0);
      chk("rst mem_clken", {31'h0, ifA.mem_clken}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post-rst mem_clken", {31'h0, ifA.mem_clken}, 32'h1);
      chk("post-rst in_ready idle", {31'h0, ifA.in_ready}, 32'h0);

      // Table-driven frames on the full-depth instance
      for (int f = 0; f < 3; f++) begin
         pulse_start();
         send(frames[f].first, frames[f].step, frames[f].n, 1'b1, edges, lows);
         chk($sformatf("frame%0d edges", f), 32'(edges), 32'(frames[f].exp_edges));
         chk($sformatf("frame%0d ready-low cycles", f), 32'(lows), 32'(frames[f].exp_lows));
         wait_done($sformatf("frame%0d", f), 2, 16'(frames[f].exp_cnt));
         chk($sformatf("frame%0d idle in_ready", f), {31'h0, ifA.in_ready}, 32'h0);
      end

      // Abort: 6 bytes, then start with a byte offered alongside, then 01..04
      dbefore = doneA;
      pulse_start();
      send(8'hA0, 8'h01, 6, 1'b0, edges, lows);
      s_start = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hFF;
      @(posedge clk); #1;
      s_start = 1'b0;
      s_valid = 1'b0;
      chk("abort byte_count cleared", {16'h0, ifA.byte_count}, 32'h0);
      send(8'h01, 8'h01, 4, 1'b1, edges, lows);
      wait_done("abort-new", 2, 16'd4);
      chk("abort done pulses", 32'(doneA - dbefore), 32'd1);

      // Overflow on DEPTH=2 instance
      sel = 1'b1;
      pulse_start();
      send(8'h01, 8'h01, 12, 1'b1, edges, lows);
      chk("ovf edges", 32'(edges), 32'd14);
      wait_done("ovf", 1, 16'd8);
      chk("ovf flag", {31'h0, ifB.overflow}, 32'h1);
      pulse_start();
      chk("ovf cleared by start", {31'h0, ifB.overflow}, 32'h0);
      chk("ovf count cleared by start", {16'h0, ifB.byte_count}, 32'h0);
      sel = 1'b0;

      // Reset during a WRITE cycle
      nwr = wq1.size();
      pulse_start();
      send(8'h55, 8'h01, 4, 1'b0, edges, lows);
      chk("pre-rst mem_write", {31'h0, ifA.mem_write}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("async rst mem_write", {31'h0, ifA.mem_write}, 32'h0);
      chk("async rst mem_chipselect", {31'h0, ifA.mem_chipselect}, 32'h0);
      chk("async rst byte_count", {16'h0, ifA.byte_count}, 32'h0);
      chk("async rst mem_clken", {31'h0, ifA.mem_clken}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("after rst in_ready", {31'h0, ifA.in_ready}, 32'h0);
      chk("after rst mem_clken", {31'h0, ifA.mem_clken}, 32'h1);
      chk("no write across reset", 32'(wq1.size()), 32'(nwr));

      // Captured write streams against expected tables
      chk("dut write count", 32'(wq1.size()), 32'd11);
      for (int i = 0; i < 11 && i < wq1.size(); i++) begin
         chk($sformatf("wr%0d addr", i), {19'h0, wq1[i].addr}, {19'h0, exp1[i].addr});
         chk($sformatf("wr%0d be", i), {28'h0, wq1[i].be}, {28'h0, exp1[i].be});
         chk($sformatf("wr%0d data", i), wq1[i].data, exp1[i].data);
      end
      chk("dut2 write count", 32'(wq2.size()), 32'd2);
      for (int i = 0; i < 2 && i < wq2.size(); i++) begin
         chk($sformatf("ovf wr%0d addr", i), {19'h0, wq2[i].addr}, {19'h0, exp2[i].addr});
         chk($sformatf("ovf wr%0d be", i), {28'h0, wq2[i].be}, {28'h0, exp2[i].be});
         chk($sformatf("ovf wr%0d data", i), wq2[i].data, exp2[i].data);
      end
      chk("chipselect tracks write", 32'(cs_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
